// File: rtl/pe_acc_add_ctr_if.sv
// Bundles the mode, data, strobe and result signals of the lane accumulator/adder.
interface pe_acc_add_ctr_if #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32
) ();
  logic [3:0]                          i_npe_mode;
  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_mdata;
  logic                                i_mdata_vld;
  logic [DATA_COPIES*DATA_WIDTH-1:0]   i_wdata;
  logic                                i_wdata_vld;
  logic                                i_acc_out;
  logic [DATA_COPIES*2*DATA_WIDTH-1:0] o_result;
  logic                                o_result_vld;

  modport master (
    output i_npe_mode, i_mdata, i_mdata_vld, i_wdata, i_wdata_vld, i_acc_out,
    input  o_result, o_result_vld
  );

  modport slave (
    input  i_npe_mode, i_mdata, i_mdata_vld, i_wdata, i_wdata_vld, i_acc_out,
    output o_result, o_result_vld
  );
endinterface

// File: rtl/pe_acc_add_ctr.sv
// Per-lane signed accumulator (ACC) and pairwise adder (ADD) with one-cycle result latency.
module pe_acc_add_ctr #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32
) (
  input logic           i_clk,
  input logic           i_rst_n,
  pe_acc_add_ctr_if.slave bus
);
  localparam int RW = 2 * DATA_WIDTH;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_ACC,
    MODE_ADD
  } mode_t;

  mode_t                      prev_mode;
  mode_t                      cur_mode;
  logic                       mode_chg;
  logic [RW-1:0]              acc      [DATA_COPIES];
  logic [RW-1:0]              acc_nxt  [DATA_COPIES];
  logic [RW-1:0]              base     [DATA_COPIES];
  logic [RW-1:0]              acc_sum  [DATA_COPIES];
  logic [DATA_COPIES*RW-1:0]  result;
  logic [DATA_COPIES*RW-1:0]  result_nxt;
  logic                       result_vld;
  logic                       result_vld_nxt;

  function automatic logic [RW-1:0] sext(input logic [DATA_WIDTH-1:0] v);
    return {{DATA_WIDTH{v[DATA_WIDTH-1]}}, v};
  endfunction

  // State register: previous mode, accumulators and the registered result.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      prev_mode  <= MODE_IDLE;
      result     <= '0;
      result_vld <= 1'b0;
      for (int unsigned k = 0; k < DATA_COPIES; k++) acc[k] <= '0;
    end else begin
      prev_mode  <= cur_mode;
      result     <= result_nxt;
      result_vld <= result_vld_nxt;
      for (int unsigned k = 0; k < DATA_COPIES; k++) acc[k] <= acc_nxt[k];
    end
  end

  // Mode decode; a change of mode restarts accumulation from zero.
  always_comb begin
    case (bus.i_npe_mode)
      4'h4:    cur_mode = MODE_ACC;
      4'h5:    cur_mode = MODE_ADD;
      default: cur_mode = MODE_IDLE;
    endcase
    mode_chg = (cur_mode != prev_mode);
  end

  // Lane datapath: next accumulator, next result and its valid pulse.
  always_comb begin
    result_nxt     = result;
    result_vld_nxt = 1'b0;
    for (int unsigned k = 0; k < DATA_COPIES; k++) begin
      base[k]    = mode_chg ? '0 : acc[k];
      acc_sum[k] = base[k] + (bus.i_mdata_vld ?
                   sext(bus.i_mdata[k*DATA_WIDTH +: DATA_WIDTH]) : '0);
      acc_nxt[k] = base[k];
      case (cur_mode)
        MODE_ACC: begin
          // A sample in the strobe cycle goes into the emitted result, then the lane restarts at 0.
          if (bus.i_acc_out) begin
            result_nxt[k*RW +: RW] = acc_sum[k];
            acc_nxt[k]             = '0;
          end else begin
            acc_nxt[k] = acc_sum[k];
          end
        end
        MODE_ADD: begin
          if (bus.i_mdata_vld && bus.i_wdata_vld)
            result_nxt[k*RW +: RW] = sext(bus.i_mdata[k*DATA_WIDTH +: DATA_WIDTH]) +
                                     sext(bus.i_wdata[k*DATA_WIDTH +: DATA_WIDTH]);
        end
        default: ;
      endcase
    end
    result_vld_nxt = ((cur_mode == MODE_ACC) && bus.i_acc_out) ||
                     ((cur_mode == MODE_ADD) && bus.i_mdata_vld && bus.i_wdata_vld);
  end

  assign bus.o_result     = result;
  assign bus.o_result_vld = result_vld;
endmodule

// File: tb/tb_pe_acc_add_ctr.sv
// Bench for pe_acc_add_ctr: directed vector table, wrap sequence, then random vs. reference model.
module tb_pe_acc_add_ctr;
  localparam int DW = 8;
  localparam int DC = 32;
  localparam int RW = 16;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;

  pe_acc_add_ctr_if #(.DATA_WIDTH(DW), .DATA_COPIES(DC)) bus ();

  pe_acc_add_ctr #(.DATA_WIDTH(DW), .DATA_COPIES(DC)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: mathematical per-lane sums, truncated only when reported.
  longint             macc [DC];
  int                 mprev;
  logic [DC*RW-1:0]   mres;
  logic               mvld;

  function automatic int lane_of(input logic [DC*DW-1:0] v, input int k);
    logic signed [DW-1:0] b;
    b = v[k*DW +: DW];
    return int'(b);
  endfunction

  task automatic model_step();
    int md;
    if (!i_rst_n) begin
      for (int k = 0; k < DC; k++) macc[k] = 0;
      mprev = 0;
      mres  = '0;
      mvld  = 1'b0;
      return;
    end
    md = (bus.i_npe_mode == 4'h4) ? 1 : (bus.i_npe_mode == 4'h5) ? 2 : 0;
    if (md != mprev) for (int k = 0; k < DC; k++) macc[k] = 0;
    mprev = md;
    mvld  = 1'b0;
    if (md == 1) begin
      if (bus.i_mdata_vld) for (int k = 0; k < DC; k++) macc[k] += lane_of(bus.i_mdata, k);
      if (bus.i_acc_out) begin
        for (int k = 0; k < DC; k++) begin
          mres[k*RW +: RW] = RW'(macc[k]);
          macc[k] = 0;
        end
        mvld = 1'b1;
      end
    end else if (md == 2 && bus.i_mdata_vld && bus.i_wdata_vld) begin
      for (int k = 0; k < DC; k++)
        mres[k*RW +: RW] = RW'(lane_of(bus.i_mdata, k) + lane_of(bus.i_wdata, k));
      mvld = 1'b1;
    end
  endtask

  task automatic step(input logic [3:0] mode, input logic [DC*DW-1:0] m, input logic mv,
                      input logic [DC*DW-1:0] w, input logic wv, input logic ao, input logic rst);
    @(negedge i_clk);
    bus.i_npe_mode  = mode;
    bus.i_mdata     = m;
    bus.i_mdata_vld = mv;
    bus.i_wdata     = w;
    bus.i_wdata_vld = wv;
    bus.i_acc_out   = ao;
    i_rst_n         = rst;
    model_step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [DC*RW-1:0] act,
                            input logic [DC*RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  mode;
    int          lane;
    int          m;
    logic        mv;
    int          w;
    logic        wv;
    logic        ao;
    logic        rst;
    logic        ev;
    logic [15:0] elane;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] mode, input int lane, input int m, input logic mv,
                              input int w, input logic wv, input logic ao, input logic rst,
                              input logic ev, input logic [15:0] elane);
    vec_t v;
    v.mode = mode; v.lane = lane; v.m = m; v.mv = mv; v.w = w; v.wv = wv;
    v.ao = ao; v.rst = rst; v.ev = ev; v.elane = elane;
    return v;
  endfunction

  vec_t tbl [22];

  initial begin
    logic [DC*DW-1:0] m;
    logic [DC*DW-1:0] w;
    logic [3:0]       rmode;
    logic [3:0]       modes [6];

    bus.i_npe_mode  = 4'h0;
    bus.i_mdata     = '0;
    bus.i_mdata_vld = 1'b0;
    bus.i_wdata     = '0;
    bus.i_wdata_vld = 1'b0;
    bus.i_acc_out   = 1'b0;

    //        mode  lane  m    mv  w    wv  ao  rst ev  lane value
    tbl[0]  = mk(4'h0, 0,    0,   0,  0,   0,  0,  0,  0, 16'h0000);
    tbl[1]  = mk(4'h4, 0,    3,   1,  0,   0,  0,  1,  0, 16'h0000);
    tbl[2]  = mk(4'h4, 0,    5,   1,  0,   0,  0,  1,  0, 16'h0000);
    tbl[3]  = mk(4'h4, 0,   -2,   1,  0,   0,  1,  1,  1, 16'h0006);
    tbl[4]  = mk(4'h4, 0,    7,   1,  0,   0,  1,  1,  1, 16'h0007);
    tbl[5]  = mk(4'h4, 0,    0,   0,  0,   0,  0,  1,  0, 16'h0007);
    tbl[6]  = mk(4'h4, 0,   10,   1,  0,   0,  0,  1,  0, 16'h0007);
    tbl[7]  = mk(4'h5, 0,    1,   1,  0,   0,  1,  1,  0, 16'h0007);
    tbl[8]  = mk(4'h4, 0,    1,   1,  0,   0,  1,  1,  1, 16'h0001);
    tbl[9]  = mk(4'h5, 31, -128,  1, -1,   1,  0,  1,  1, 16'hFF7F);
    tbl[10] = mk(4'h5, 31, -128,  1,  0,   0,  0,  1,  0, 16'hFF7F);
    tbl[11] = mk(4'h4, 31,   4,   1,  0,   0,  0,  1,  0, 16'hFF7F);
    tbl[12] = mk(4'h4, 31,   4,   1,  0,   0,  0,  1,  0, 16'hFF7F);
    tbl[13] = mk(4'h4, 31,   4,   1,  0,   0,  1,  0,  0, 16'h0000);
    tbl[14] = mk(4'h4, 0,    0,   0,  0,   0,  0,  0,  0, 16'h0000);
    tbl[15] = mk(4'h4, 0,    2,   1,  0,   0,  1,  1,  1, 16'h0002);
    tbl[16] = mk(4'h0, 0,   50,   1,  9,   1,  1,  1,  0, 16'h0002);
    tbl[17] = mk(4'h0, 0,   20,   1,  0,   0,  1,  1,  0, 16'h0002);
    tbl[18] = mk(4'h7, 0,    0,   0,  0,   0,  0,  1,  0, 16'h0002);
    tbl[19] = mk(4'h4, 0,    3,   1, 100,  1,  0,  1,  0, 16'h0002);
    tbl[20] = mk(4'h4, 0,    4,   1,  0,   0,  1,  1,  1, 16'h0007);
    tbl[21] = mk(4'h4, 0,   -5,   1,  0,   0,  1,  1,  1, 16'hFFFB);

    // Reset state.
    step(4'h0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_wide("reset_result", bus.o_result, '0);
    check("reset_vld", 64'(bus.o_result_vld), 64'(0));

    // Directed vectors.
    for (int i = 0; i < 22; i++) begin
      m = '0;
      w = '0;
      m[tbl[i].lane*DW +: DW] = 8'(tbl[i].m);
      w[tbl[i].lane*DW +: DW] = 8'(tbl[i].w);
      step(tbl[i].mode, m, tbl[i].mv, w, tbl[i].wv, tbl[i].ao, tbl[i].rst);
      check($sformatf("vec%0d_vld", i), 64'(bus.o_result_vld), 64'(tbl[i].ev));
      check($sformatf("vec%0d_lane%0d", i, tbl[i].lane),
            64'(bus.o_result[tbl[i].lane*RW +: RW]), 64'(tbl[i].elane));
    end

    // Accumulator wrap: 260 samples of 127 on lane 0.
    step(4'h0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    m = '0;
    m[DW-1:0] = 8'd127;
    for (int i = 0; i < 260; i++) begin
      step(4'h4, m, 1'b1, '0, 1'b0, (i == 259), 1'b1);
      if (i == 258) check("wrap_no_early_vld", 64'(bus.o_result_vld), 64'(0));
    end
    check("wrap_vld", 64'(bus.o_result_vld), 64'(1));
    check("wrap_lane0", 64'(bus.o_result[RW-1:0]), 64'(16'h80FC));
    step(4'h4, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("wrap_pulse_end", 64'(bus.o_result_vld), 64'(0));
    check("wrap_hold", 64'(bus.o_result[RW-1:0]), 64'(16'h80FC));

    // Random stimulus against the reference model.
    modes[0] = 4'h4; modes[1] = 4'h5; modes[2] = 4'h0;
    modes[3] = 4'h4; modes[4] = 4'h5; modes[5] = 4'h9;
    rmode = 4'h4;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(7) == 0) rmode = modes[$urandom_range(5)];
      for (int j = 0; j < DC*DW/32; j++) begin
        m[j*32 +: 32] = $urandom;
        w[j*32 +: 32] = $urandom;
      end
      step(rmode, m, 1'($urandom_range(3) != 0), w, 1'($urandom_range(1)),
           1'($urandom_range(5) == 0), 1'($urandom_range(63) != 0));
      check($sformatf("rand%0d_vld", i), 64'(bus.o_result_vld), 64'(mvld));
      check_wide($sformatf("rand%0d_result", i), bus.o_result, mres);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
